// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of external JK flip-flops: computes per-bit J/K
// excitation for clear/load/invert/count commands and verifies the bank readback.
module jk_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INV  = 3'd3;
    localparam logic [2:0] OP_UP   = 3'd4;
    localparam logic [2:0] OP_DOWN = 3'd5;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // In IDLE the incoming opcode drives the target logic; afterwards the captured one does.
    logic [2:0]       sel_op;
    logic             is_inv;
    logic [WIDTH-1:0] tgt_calc;
    logic [WIDTH-1:0] j_calc;
    logic [WIDTH-1:0] k_calc;

    assign sel_op = (state_q == S_IDLE) ? cmd_op_i : op_q;
    assign is_inv = (sel_op == OP_INV);

    always_comb begin
        tgt_calc = ZERO;
        case (sel_op)
            OP_LOAD: tgt_calc = cmd_data_i;
            OP_INV:  tgt_calc = ~q_i;
            OP_UP:   tgt_calc = q_i + ONE;
            OP_DOWN: tgt_calc = q_i - ONE;
            default: tgt_calc = ZERO;
        endcase
    end

    // Only bits that must change are excited; INV toggles everything.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
            assign j_calc[gi] = is_inv | ( tgt_calc[gi] & ~q_i[gi]);
            assign k_calc[gi] = is_inv | (~tgt_calc[gi] &  q_i[gi]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        j_d     = ZERO;
        k_d     = ZERO;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d = cmd_op_i;
                    case (cmd_op_i)
                        OP_NOP: state_d = S_FIN;
                        OP_CLR, OP_LOAD, OP_INV: begin
                            cnt_d   = ONE;
                            tgt_d   = tgt_calc;
                            j_d     = j_calc;
                            k_d     = k_calc;
                            state_d = S_EXEC;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_data_i == ZERO) begin
                                state_d = S_FIN;
                            end else begin
                                cnt_d   = cmd_data_i;
                                tgt_d   = tgt_calc;
                                j_d     = j_calc;
                                k_d     = k_calc;
                                state_d = S_EXEC;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_FIN;
                        end
                    endcase
                end
            end
            S_EXEC: state_d = S_CHECK;
            S_CHECK: begin
                if (q_i != tgt_q) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q - ONE;
                if (cnt_q != ONE) begin
                    tgt_d   = tgt_calc;
                    j_d     = j_calc;
                    k_d     = k_calc;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            tgt_q   <= ZERO;
            j_q     <= ZERO;
            k_q     <= ZERO;
            cnt_q   <= ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign done_o      = (state_q == S_FIN);
    assign j_o         = j_q;
    assign k_o         = k_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: models the JK bank, predicts a per-cycle output trace
// for every accepted command and compares the DUT against it every cycle.
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] j_w, k_w;
    logic       done_w, err_w;

    logic [3:0] bank_q = 4'b1010;
    logic [3:0] stuck  = 4'b0000;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rdy;
        logic [3:0] j;
        logic [3:0] k;
        logic       done;
        logic       err;
        logic       chk_q;
        logic [3:0] q;
    } rec_t;

    rec_t       exp_q[$];
    logic [3:0] model_q   = 4'b1010;
    logic       err_model = 1'b0;
    logic [3:0] first_j, first_k;
    int         last_lat;

    jk_bank_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .q_i         (bank_q),
        .j_o         (j_w),
        .k_o         (k_w),
        .done_o      (done_w),
        .err_o       (err_w)
    );

    always #5 clk = ~clk;

    // External JK bank, optionally with bits stuck at 0.
    always @(posedge clk)
        bank_q <= ((j_w & ~bank_q) | (~k_w & bank_q)) & ~stuck;

    function automatic logic [3:0] tgt_of(input logic [2:0] op, input logic [3:0] q, input logic [3:0] d);
        case (op)
            3'd2:    return d;
            3'd3:    return ~q;
            3'd4:    return q + 4'd1;
            3'd5:    return q - 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic rec_t mk(input logic rdy, input logic [3:0] j, input logic [3:0] k,
                                input logic done, input logic err, input logic chk, input logic [3:0] q);
        rec_t r;
        r.rdy = rdy; r.j = j; r.k = k; r.done = done; r.err = err; r.chk_q = chk; r.q = q;
        return r;
    endfunction

    // Expected outputs for cycles 1.. after the accept edge, ending with one IDLE cycle.
    task automatic push_trace(input logic [2:0] op, input logic [3:0] data);
        logic [3:0] qc, t, jj, kk, after;
        logic       e;
        int         n;
        qc = model_q;
        e  = err_model;
        first_j = 4'd0;
        first_k = 4'd0;
        if (op > 3'd5) begin
            e = 1'b1;
            n = 0;
        end else if (op == 3'd0) n = 0;
        else if (op >= 3'd4)     n = int'(data);
        else                     n = 1;
        for (int s = 0; s < n; s++) begin
            t = tgt_of(op, qc, data);
            if (op == 3'd3) begin
                jj = 4'hF; kk = 4'hF;
            end else begin
                jj = t & ~qc; kk = ~t & qc;
            end
            if (s == 0) begin
                first_j = jj; first_k = kk;
            end
            exp_q.push_back(mk(1'b0, jj, kk, 1'b0, e, 1'b0, 4'd0));
            after = t & ~stuck;
            exp_q.push_back(mk(1'b0, 4'd0, 4'd0, 1'b0, e, 1'b1, after));
            if (after != t) e = 1'b1;
            qc = after;
        end
        exp_q.push_back(mk(1'b0, 4'd0, 4'd0, 1'b1, e, 1'b0, 4'd0));
        exp_q.push_back(mk(1'b1, 4'd0, 4'd0, 1'b0, e, 1'b0, 4'd0));
        model_q   = qc;
        err_model = e;
        last_lat  = 2 * n + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the predicted trace (idle when nothing is pending).
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        else r = mk(1'b1, 4'd0, 4'd0, 1'b0, err_model, 1'b0, 4'd0);
        n_tests++;
        if ({cmd_ready, j_w, k_w, done_w, err_w} !== {r.rdy, r.j, r.k, r.done, r.err} ||
            (r.chk_q && bank_q !== r.q)) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got rdy=%b j=%b k=%b done=%b err=%b q=%b, expected rdy=%b j=%b k=%b done=%b err=%b q=%b(chk=%b)",
                     $time, cmd_ready, j_w, k_w, done_w, err_w, bank_q,
                     r.rdy, r.j, r.k, r.done, r.err, r.q, r.chk_q);
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] data);
        int guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (exp_q.size() != 0 && guard < 200);
        if (exp_q.size() != 0) chk("send_idle_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        push_trace(op, data);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 4'($urandom);
        $display("[TB] cmd op=%0d data=%0d accepted at t=%0t", op, data, $time);
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_w && lat < 100);
        chk(name, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_j", 32'(j_w), 32'd0);
        chk("rst_k", 32'(k_w), 32'd0);
        chk("rst_done", 32'(done_w), 32'd0);
        chk("rst_err", 32'(err_w), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        #1 rst_n = 1'b1;

        send(3'd1, 4'd0);
        chk("clr_model_j", 32'(first_j), 32'h0);
        chk("clr_model_k", 32'(first_k), 32'hA);
        wait_done("clr_lat", 3);
        chk("clr_q", 32'(bank_q), 32'h0);
        chk("clr_err", 32'(err_w), 32'd0);

        send(3'd2, 4'b0110);
        chk("load_model_j", 32'(first_j), 32'h6);
        chk("load_model_k", 32'(first_k), 32'h0);
        wait_done("load_lat", 3);
        chk("load_q", 32'(bank_q), 32'h6);

        send(3'd2, 4'b1110);
        wait_done("load2_lat", 3);
        send(3'd4, 4'd3);
        wait_done("up3_lat", 7);
        chk("up3_q", 32'(bank_q), 32'h1);
        chk("up3_err", 32'(err_w), 32'd0);

        send(3'd2, 4'b0101);
        wait_done("load3_lat", 3);
        send(3'd3, 4'd0);
        chk("inv_model_jk", 32'({first_j, first_k}), 32'hFF);
        wait_done("inv_lat", 3);
        chk("inv_q", 32'(bank_q), 32'hA);
        send(3'd5, 4'd0);
        wait_done("down0_lat", 1);
        chk("down0_q", 32'(bank_q), 32'hA);

        stuck = 4'b0001;
        send(3'd2, 4'b0001);
        wait_done("stuck_lat", 3);
        stuck = 4'b0000;
        chk("stuck_err", 32'(err_w), 32'd1);
        send(3'd1, 4'd0);
        wait_done("after_stuck_lat", 3);
        chk("err_sticky", 32'(err_w), 32'd1);

        send(3'd7, 4'd0);
        wait_done("illegal_lat", 1);
        chk("illegal_err", 32'(err_w), 32'd1);

        send(3'd2, 4'b0101);
        wait_done("load4_lat", 3);
        send(3'd4, 4'd4);
        repeat (3) @(negedge clk);
        #1;
        chk("exec2_j", 32'(j_w), 32'h1);
        rst_n = 1'b0;
        exp_q.delete();
        err_model = 1'b0;
        model_q   = 4'b0110;
        #1;
        chk("rst_mid_jk", 32'({j_w, k_w}), 32'h00);
        chk("rst_mid_done", 32'(done_w), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rel_err", 32'(err_w), 32'd0);
        repeat (8) @(negedge clk);
        chk("rst_kept_q", 32'(bank_q), 32'h6);

        // Wrap-around from all-ones.
        send(3'd2, 4'hF);
        wait_done("load_f_lat", 3);
        send(3'd4, 4'd1);
        wait_done("wrap_up_lat", 3);
        chk("wrap_up_q", 32'(bank_q), 32'h0);
        send(3'd5, 4'd1);
        wait_done("wrap_down_lat", 3);
        chk("wrap_down_q", 32'(bank_q), 32'hF);
        chk("wrap_err", 32'(err_w), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(0, 15));
            send((r < 4'd14) ? 3'(r % 4'd6) : 3'(4'd6 + r % 4'd2), 4'($urandom_range(0, 15)));
            wait_done("rand_lat", last_lat);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
